// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type, framing constants and parity helper for the UART transmitter
// Optional macro: UART_TX_BREAK_EN adds the BREAK state to the state enum.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd5
`endif
  } tx_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic data_parity(input logic [MAX_DATA_WIDTH-1:0] word,
                                       input logic                      parity_type);
    return (^word) ^ (parity_type == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous word FIFO feeding the UART transmitter
// Power-of-two depth: pointers wrap naturally, occupancy kept in a separate count register.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            pop,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised FIFO-buffered UART transmitter with runtime parity/stop-bit selection
// Optional macro: UART_TX_BREAK_EN adds the Break input and the BREAK line state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           Data_In,
  input  logic                            Data_Valid,
  output logic                            Ready,
  input  logic                            Parity_Enable,
  input  logic                            Parity_Type,
  input  logic                            Stop_Bits,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Fifo_Count,
  output logic                            Busy,
  output logic                            S_Data
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                            Break
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  sh_par_en;
  logic                  sh_par_bit;
  logic                  sh_stop2;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  break_req;
  logic                  cnt_done;
  logic                  line_bit;

`ifdef UART_TX_BREAK_EN
  assign break_req = Break;
`else
  assign break_req = 1'b0;
`endif

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !break_req;
  assign cnt_done = (cnt == CNT_LAST);
  assign Ready    = !fifo_full;

  uart_tx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RST),
    .push (Data_Valid),
    .wdata(Data_In),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(Fifo_Count)
  );

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shreg[0];
      ST_PARITY: line_bit = sh_par_bit;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  line_bit = 1'b0;
`endif
      default:   line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      sh_par_en  <= 1'b0;
      sh_par_bit <= 1'b0;
      sh_stop2   <= STOP_ONE;
      S_Data     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      // Outputs trail the state by one cycle; this is what makes the single IDLE cycle visible between frames.
      S_Data <= line_bit;
      Busy   <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state    <= ST_BREAK;
            sh_stop2 <= STOP_ONE;
          end
`endif
          if (fifo_pop) begin
            state      <= ST_START;
            shreg      <= fifo_rdata;
            sh_par_en  <= Parity_Enable;
            sh_par_bit <= data_parity(MAX_DATA_WIDTH'(fifo_rdata), Parity_Type);
            sh_stop2   <= (Stop_Bits == STOP_TWO);
          end
        end
        ST_START: begin
          if (cnt_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_done) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              stop_idx <= 1'b0;
              state    <= sh_par_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt_done) begin
            cnt      <= '0;
            stop_idx <= 1'b0;
            state    <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_done) begin
            cnt <= '0;
            if (stop_idx == sh_stop2) begin
              state <= ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          cnt      <= '0;
          stop_idx <= 1'b0;
          if (!break_req) begin
            state <= ST_STOP;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param; Break sequence built when UART_TX_BREAK_EN is defined
module tb_uart_tx_param;

  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int CPB = 16;
  localparam int CW  = $clog2(FD + 1);

  logic          clk           = 1'b0;
  logic          rst_n         = 1'b0;
  logic [DW-1:0] data_in       = '0;
  logic          data_valid    = 1'b0;
  logic          parity_enable = 1'b0;
  logic          parity_type   = 1'b0;
  logic          stop_bits     = 1'b0;
  logic          ready;
  logic          busy;
  logic          s_data;
  logic [CW-1:0] fifo_count;
`ifdef UART_TX_BREAK_EN
  logic          brk           = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
    logic          sb;
  } frame_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
    logic          sb;
    logic          exp_par;
    int            exp_cycles;
  } vec_t;

  frame_t exp_q[$];
  vec_t   vecs[8];
  logic   line_cap[512];

  uart_tx_param #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (FD),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .Data_In      (data_in),
    .Data_Valid   (data_valid),
    .Ready        (ready),
    .Parity_Enable(parity_enable),
    .Parity_Type  (parity_type),
    .Stop_Bits    (stop_bits),
    .Fifo_Count   (fifo_count),
    .Busy         (busy),
    .S_Data       (s_data)
`ifdef UART_TX_BREAK_EN
    ,
    .Break        (brk)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, then one or two stop bits.
  function automatic int frame_len(frame_t f);
    return 1 + DW + (f.pe ? 1 : 0) + 1 + (f.sb ? 1 : 0);
  endfunction

  function automatic logic model_parity(frame_t f);
    int ones;
    ones = $countones(f.d);
    return f.pt ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic logic frame_bit(frame_t f, int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return f.d[i-1];
    if (f.pe && i == DW + 1) return model_parity(f);
    return 1'b1;
  endfunction

  task automatic wait_start(input string name, output bit ok);
    int n;
    n = 0;
    while (s_data !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    ok = (s_data === 1'b0);
    if (!ok) check({name, "_start_timeout"}, s_data, 0);
  endtask

  task automatic check_next(input string name);
    frame_t        f;
    bit            ok;
    int            bad;
    logic [DW-1:0] rx;
    wait_start(name, ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_frame: got a start bit, expected no frame", name);
      return;
    end
    f   = exp_q.pop_front();
    bad = 0;
    rx  = '0;
    for (int i = 0; i < frame_len(f); i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (s_data !== frame_bit(f, i) || busy !== 1'b1) bad++;
        if (c == CPB / 2 && i >= 1 && i <= DW) rx[i-1] = s_data;
        tick();
      end
    end
    check({name, "_wave_bad_cycles"}, bad, 0);
    check({name, "_rx_data"}, rx, f.d);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int n;
    n          = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (!ready && n < 3000) begin
      tick();
      n++;
    end
    tick();
    data_valid = 1'b0;
    exp_q.push_back('{d: w, pe: parity_enable, pt: parity_type, sb: stop_bits});
  endtask

  initial begin
    int  n;
    int  m;
    int  nw;
    int  bad;
    int  incons;
    bit  saw_full;
    bit  ok;
    logic [DW-1:0] rx;

    vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, sb: 1'b0, exp_par: 1'b0, exp_cycles: 160};
    vecs[1] = '{d: 8'h07, pe: 1'b1, pt: 1'b0, sb: 1'b0, exp_par: 1'b1, exp_cycles: 176};
    vecs[2] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, sb: 1'b0, exp_par: 1'b0, exp_cycles: 176};
    vecs[3] = '{d: 8'h00, pe: 1'b0, pt: 1'b0, sb: 1'b1, exp_par: 1'b0, exp_cycles: 176};
    vecs[4] = '{d: 8'hFF, pe: 1'b1, pt: 1'b1, sb: 1'b1, exp_par: 1'b1, exp_cycles: 192};
    vecs[5] = '{d: 8'h3C, pe: 1'b1, pt: 1'b0, sb: 1'b1, exp_par: 1'b0, exp_cycles: 192};
    vecs[6] = '{d: 8'h80, pe: 1'b1, pt: 1'b0, sb: 1'b0, exp_par: 1'b1, exp_cycles: 176};
    vecs[7] = '{d: 8'h5A, pe: 1'b0, pt: 1'b1, sb: 1'b1, exp_par: 1'b0, exp_cycles: 176};

    // Reset values
    repeat (3) tick();
    check("rst_s_data", s_data, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Latency: push at edge N, pop at N+1, start bit visible after N+2
    push_word(8'hA5);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_line_at_n", s_data, 1);
    tick();
    check("t1_line_at_n1", s_data, 1);
    check("t1_busy_at_n1", busy, 0);
    check("t1_count_after_pop", fifo_count, 0);
    tick();
    check("t1_start_at_n2", s_data, 0);
    check("t1_busy_at_n2", busy, 1);
    check_next("t1");
    check("t1_busy_after_frame", busy, 0);
    check("t1_line_after_frame", s_data, 1);

    // Table of single frames with hand-computed parity and frame length
    for (int i = 0; i < 8; i++) begin
      parity_enable = vecs[i].pe;
      parity_type   = vecs[i].pt;
      stop_bits     = vecs[i].sb;
      push_word(vecs[i].d);
      void'(exp_q.pop_back());
      wait_start($sformatf("vec%0d", i), ok);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
        line_cap[n] = s_data;
        n++;
        tick();
      end
      check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].exp_cycles);
      rx = '0;
      for (int b = 0; b < DW; b++) rx[b] = line_cap[(b + 1) * CPB + CPB / 2];
      check($sformatf("vec%0d_rx_data", i), rx, vecs[i].d);
      if (vecs[i].pe) check($sformatf("vec%0d_parity", i), line_cap[(DW + 1) * CPB + CPB / 2], vecs[i].exp_par);
      check($sformatf("vec%0d_last_stop", i), line_cap[(n > 0) ? n - 1 : 0], 1);
      repeat (3) tick();
    end

    // Back-to-back frames, two stop bits, Stop_Bits changed mid-frame
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    stop_bits     = 1'b1;
    push_word(8'h00);
    push_word(8'h00);
    fork
      begin
        repeat (60) tick();
        stop_bits = 1'b0;
        if (exp_q.size() > 0) exp_q[0].sb = 1'b0;
      end
    join_none
    check_next("t3_first");
    check("t3_gap_busy", busy, 0);
    check("t3_gap_line", s_data, 1);
    tick();
    check("t3_second_start", s_data, 0);
    check_next("t3_second");
    check("t3_idle_after", busy, 0);

    // Six words with Data_Valid held; Ready must drop exactly while the FIFO is full
    parity_enable = 1'b1;
    parity_type   = 1'b1;
    stop_bits     = 1'b0;
    incons        = 0;
    saw_full      = 1'b0;
    fork
      begin
        data_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
          data_in = DW'($urandom);
          m = 0;
          while (!ready && m < 3000) begin
            if (fifo_count != CW'(FD)) incons++;
            saw_full = 1'b1;
            tick();
            m++;
          end
          if (fifo_count == CW'(FD)) incons++;
          tick();
          exp_q.push_back('{d: data_in, pe: parity_enable, pt: parity_type, sb: stop_bits});
        end
        data_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) check_next($sformatf("t4_word%0d", k));
      end
    join
    check("t4_saw_ready_low", saw_full, 1);
    check("t4_ready_vs_count", incons, 0);
    check("t4_queue_drained", exp_q.size(), 0);

    // Randomised batches against the frame model
    for (int b = 0; b < 8; b++) begin
      nw            = $urandom_range(5, 1);
      parity_enable = 1'($urandom);
      parity_type   = 1'($urandom);
      stop_bits     = 1'($urandom);
      fork
        begin
          for (int k = 0; k < nw; k++) begin
            repeat ($urandom_range(40, 0)) tick();
            push_word(DW'($urandom));
          end
        end
        begin
          for (int k = 0; k < nw; k++) check_next($sformatf("rnd%0d_%0d", b, k));
        end
      join
    end

    // Reset mid-DATA with two words still queued
    parity_enable = 1'b0;
    stop_bits     = 1'b0;
    push_word(8'h3C);
    push_word(8'h11);
    push_word(8'h22);
    wait_start("t5", ok);
    repeat (CPB * 3) tick();
    check("t5_count_before_rst", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_s_data", s_data, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_fifo_count", fifo_count, 0);
    check("t5_rst_ready", ready, 1);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (s_data !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) bad++;
      tick();
    end
    check("t5_quiet_after_reset", bad, 0);
    push_word(8'h96);
    check_next("t5_new_word");

`ifdef UART_TX_BREAK_EN
    // Break for 100 cycles while idle, with a word queued during the break
    brk = 1'b1;
    fork
      begin
        repeat (100) tick();
        brk = 1'b0;
      end
      begin
        repeat (10) tick();
        push_word(8'h6B);
      end
    join_none
    n = 0;
    while (s_data !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    m = -1;
    while (s_data === 1'b0 && busy === 1'b1 && n < 500) begin
      if (n == 50) m = int'(fifo_count);
      n++;
      tick();
    end
    check("brk_low_cycles", n, 100);
    check("brk_count_held", m, 1);
    n = 0;
    while (s_data === 1'b1 && busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("brk_stop_cycles", n, 16);
    check("brk_idle_busy", busy, 0);
    check_next("brk_queued_word");
`endif

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
